// File: rtl/bp_be_fe_queue_rx.sv
// bp_be_fe_queue_rx: backend receiver for the FE->BE fetch queue.
// Circular store with three pointers: write (wptr), speculative read (sptr)
// and commit (cptr). Entries stay resident until commit so the read side can
// be rewound (roll) or the whole queue discarded (clr).
// Optional feature: define BP_FE_QUEUE_RX_BYPASS_EN to forward an incoming
// packet straight to issue_pkt_o when the speculative read side is caught up.
module bp_be_fe_queue_rx #(
    parameter int fe_queue_width_p = 128,
    parameter int els_p            = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [fe_queue_width_p-1:0] fe_queue_i,
    input  logic                        fe_queue_v_i,
    output logic                        fe_queue_ready_and_o,
    output logic [fe_queue_width_p-1:0] issue_pkt_o,
    output logic                        issue_v_o,
    input  logic                        issue_yumi_i,
    input  logic                        commit_v_i,
    input  logic                        roll_v_i,
    input  logic                        clr_v_i,
    output logic                        empty_o
);

    localparam int lg_els_lp    = $clog2(els_p);
    localparam int ptr_width_lp = lg_els_lp + 1;
    localparam logic [ptr_width_lp-1:0] ptr_one_lp = ptr_width_lp'(1);

    logic [fe_queue_width_p-1:0] r_mem [els_p];
    logic [ptr_width_lp-1:0]     r_wptr, r_sptr, r_cptr;
    logic [ptr_width_lp-1:0]     w_wptr_next, w_sptr_next, w_cptr_next;
    logic [ptr_width_lp-1:0]     w_cptr_roll;
    logic                        w_full;
    logic                        w_enq;
    logic                        w_caught_up;

    // Full is judged against the commit pointer: uncommitted entries still occupy slots.
    assign w_full = (r_wptr[ptr_width_lp-1] != r_cptr[ptr_width_lp-1]) &&
                    (r_wptr[lg_els_lp-1:0] == r_cptr[lg_els_lp-1:0]);
    assign fe_queue_ready_and_o = ~w_full;
    assign w_enq       = fe_queue_v_i & ~w_full & ~clr_v_i;
    assign w_caught_up = (r_sptr == r_wptr);
    assign empty_o     = (r_wptr == r_cptr);

`ifdef BP_FE_QUEUE_RX_BYPASS_EN
    // Issue side: stored packet, or the incoming packet when nothing is pending.
    always_comb begin
        issue_v_o   = ~w_caught_up;
        issue_pkt_o = r_mem[r_sptr[lg_els_lp-1:0]];
        if (w_caught_up && w_enq && !roll_v_i) begin
            issue_v_o   = 1'b1;
            issue_pkt_o = fe_queue_i;
        end
    end
`else
    // Issue side: only stored packets, so no path from fe_queue_* to issue_*.
    always_comb begin
        issue_v_o   = ~w_caught_up;
        issue_pkt_o = r_mem[r_sptr[lg_els_lp-1:0]];
    end
`endif

    // Pointer next-state with clr > roll > independent enqueue/yumi/commit.
    always_comb begin
        w_wptr_next = r_wptr;
        w_sptr_next = r_sptr;
        w_cptr_next = r_cptr;
        w_cptr_roll = commit_v_i ? (r_cptr + ptr_one_lp) : r_cptr;
        if (clr_v_i) begin
            w_sptr_next = r_wptr;
            w_cptr_next = r_wptr;
        end else if (roll_v_i) begin
            w_wptr_next = w_enq ? (r_wptr + ptr_one_lp) : r_wptr;
            w_cptr_next = w_cptr_roll;
            w_sptr_next = w_cptr_roll;
        end else begin
            w_wptr_next = w_enq        ? (r_wptr + ptr_one_lp) : r_wptr;
            w_sptr_next = issue_yumi_i ? (r_sptr + ptr_one_lp) : r_sptr;
            w_cptr_next = commit_v_i   ? (r_cptr + ptr_one_lp) : r_cptr;
        end
    end

    // Pointer registers; reset empties the queue immediately.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr <= '0;
            r_sptr <= '0;
            r_cptr <= '0;
        end else begin
            r_wptr <= w_wptr_next;
            r_sptr <= w_sptr_next;
            r_cptr <= w_cptr_next;
        end
    end

    // Packet storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr[lg_els_lp-1:0]] <= fe_queue_i;
        end
    end

`ifndef SYNTHESIS
    // Protocol checks on the consumer side.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && !clr_v_i) begin
            assert (!(issue_yumi_i && !issue_v_o));
            assert (!(commit_v_i && (r_cptr == r_sptr)));
        end
    end
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_rx.sv
// tb_bp_be_fe_queue_rx: randomized + directed bench for bp_be_fe_queue_rx.
// Reference model: a queue of uncommitted packets plus a speculative offset.
// Issued packets are pushed into a scoreboard; a monitor pops on each handshake.
module tb_bp_be_fe_queue_rx;

    localparam int W   = 128;
    localparam int ELS = 8;
`ifdef BP_FE_QUEUE_RX_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n_i;
    logic [W-1:0] fe_queue_i;
    logic         fe_queue_v_i;
    logic         fe_queue_ready_and_o;
    logic [W-1:0] issue_pkt_o;
    logic         issue_v_o;
    logic         issue_yumi_i;
    logic         commit_v_i;
    logic         roll_v_i;
    logic         clr_v_i;
    logic         empty_o;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] model_q[$];   // uncommitted packets, oldest first
    int           spec_off;     // packets already issued but not committed
    logic [W-1:0] sb_q[$];      // expected issue stream
    int           seq = 0;

    bp_be_fe_queue_rx #(.fe_queue_width_p(W), .els_p(ELS)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i),
        .fe_queue_ready_and_o(fe_queue_ready_and_o),
        .issue_pkt_o(issue_pkt_o), .issue_v_o(issue_v_o),
        .issue_yumi_i(issue_yumi_i), .commit_v_i(commit_v_i),
        .roll_v_i(roll_v_i), .clr_v_i(clr_v_i), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] new_pkt();
        seq++;
        return {32'(seq), $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        fe_queue_v_i = 1'b0; fe_queue_i = '0; issue_yumi_i = 1'b0;
        commit_v_i = 1'b0; roll_v_i = 1'b0; clr_v_i = 1'b0;
    endtask

    // One clock cycle: model predicts outputs, drives legal inputs, checks, updates.
    task automatic step(input bit v, input bit y, input bit c, input bit rl, input bit cl);
        logic [W-1:0] d;
        logic [W-1:0] exp_pkt;
        bit full, enq, exp_iv, y_eff, c_eff;
        d       = new_pkt();
        full    = (model_q.size() == ELS);
        enq     = v && !full && !cl;
        exp_iv  = (spec_off < model_q.size()) ||
                  (BYP && spec_off == model_q.size() && enq && !rl);
        exp_pkt = (spec_off < model_q.size()) ? model_q[spec_off] : d;
        y_eff   = y && exp_iv;
        c_eff   = c && (spec_off > 0);
        @(negedge clk);
        fe_queue_v_i = v; fe_queue_i = d; issue_yumi_i = y_eff;
        commit_v_i = c_eff; roll_v_i = rl; clr_v_i = cl;
        #1;
        chk("ready", {127'd0, fe_queue_ready_and_o}, {127'd0, !full});
        chk("empty", {127'd0, empty_o}, {127'd0, model_q.size() == 0});
        chk("issue_v", {127'd0, issue_v_o}, {127'd0, exp_iv});
        if (exp_iv) chk("issue_pkt", issue_pkt_o, exp_pkt);
        if (y_eff && !rl && !cl) sb_q.push_back(exp_pkt);
        if (cl) begin
            model_q.delete();
            spec_off = 0;
        end else begin
            if (enq) model_q.push_back(d);
            if (rl) begin
                if (c_eff) void'(model_q.pop_front());
                spec_off = 0;
            end else begin
                if (y_eff) spec_off++;
                if (c_eff) begin
                    void'(model_q.pop_front());
                    spec_off--;
                end
            end
        end
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any clock edge.
    task automatic mid_reset();
        @(negedge clk);
        idle_inputs();
        #3;
        reset_n_i = 1'b0;
        #1;
        chk("rst_issue_v", {127'd0, issue_v_o}, '0);
        chk("rst_ready", {127'd0, fe_queue_ready_and_o}, {127'd0, 1'b1});
        chk("rst_empty", {127'd0, empty_o}, {127'd0, 1'b1});
        model_q.delete();
        spec_off = 0;
        repeat (2) @(negedge clk);
        reset_n_i = 1'b1;
    endtask

    // Scoreboard monitor: every accepted issue must match the oldest expected packet.
    always @(negedge clk) begin
        #2;
        if (reset_n_i && issue_v_o && issue_yumi_i && !roll_v_i && !clr_v_i) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL issue_order: got %h expected none", issue_pkt_o);
            end else begin
                chk("issue_order", issue_pkt_o, sb_q.pop_front());
            end
        end
    end

    initial begin
        spec_off = 0;
        idle_inputs();
        reset_n_i = 1'b0;
        #1;
        chk("init_issue_v", {127'd0, issue_v_o}, '0);
        chk("init_ready", {127'd0, fe_queue_ready_and_o}, {127'd0, 1'b1});
        chk("init_empty", {127'd0, empty_o}, {127'd0, 1'b1});
        repeat (2) @(negedge clk);
        reset_n_i = 1'b1;

        // A,B,C back to back, yumi whenever valid
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);

        // fill to 8, 9th refused, commit while full, space next cycle
        for (int i = 0; i < ELS; i++) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);

        // enqueue 5, yumi 3, commit 1, roll, replay
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        repeat (5) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);

        // clr with 4 queued and an incoming packet
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        repeat (2) step(0, 1, 0, 0, 0);

        // cptr=2, sptr=5, then roll+commit
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
        repeat (5) step(0, 1, 0, 0, 0);
        repeat (2) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        repeat (4) step(0, 1, 0, 0, 0);

        // reset mid-stream with 6 queued
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
        mid_reset();
        repeat (2) step(0, 1, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 4, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 3);
        end
        repeat (ELS + 2) step(0, 1, 0, 0, 0);
        @(negedge clk);
        idle_inputs();
        #3;
        chk("scoreboard_drained", 128'(sb_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
